// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point FFT datapath: default sizing constants, the input
// loader state encoding and the complex sample type used by the loader, core and unloader.
package fft_pkg;

    localparam int unsigned N_POINTS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 16;

    typedef enum logic [1:0] {
        StLoad,
        StStart,
        StWaitDone
    } loader_state_e;

    // Field names avoid 'real', which is a reserved word.
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_bitrev.sv
// Combinational bit reversal of an ADDR_W-bit address.
// Ports:
//   value    - address in natural order
//   reversed - same address with bit i moved to bit ADDR_W-1-i
module fft_bitrev #(
    parameter int unsigned ADDR_W = fft_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] value,
    output logic [ADDR_W-1:0] reversed
);

    always_comb begin
        reversed = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            reversed[i] = value[ADDR_W-1-i];
        end
    end

endmodule

// File: rtl/fft_input_loader.sv
// Front end of the FFT core. Accepts complex samples over valid/ready, writes each frame into
// FFT working memory in bit-reversed order, pulses fft_start after the last write and blocks
// further input until the core reports fft_done.
// Ports:
//   clk, rst_n                  - clock and asynchronous active-low reset
//   s_valid/s_ready             - input handshake
//   s_real, s_imag, s_last      - sample payload and end-of-frame marker
//   mem_wr, mem_addr            - memory write strobe and bit-reversed address
//   mem_real, mem_imag          - memory write data (scaled by IN_SHIFT)
//   fft_start, fft_done         - core start pulse and completion (level or pulse)
//   frame_err                   - one-cycle pulse on an early or missing s_last
//   busy                        - frame in flight, from first beat until fft_done
module fft_input_loader #(
    parameter int unsigned N_POINTS = fft_pkg::N_POINTS,
    parameter int unsigned ADDR_W   = fft_pkg::ADDR_W,
    parameter int unsigned DATA_W   = fft_pkg::DATA_W,
    parameter int unsigned IN_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_real,
    input  logic [DATA_W-1:0] s_imag,
    input  logic              s_last,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_real,
    output logic [DATA_W-1:0] mem_imag,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              frame_err,
    output logic              busy
);

    import fft_pkg::*;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_POINTS - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              ready_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_real_q, mem_imag_q;
    logic              frame_err_q;

    logic              accept;
    logic              at_last;
    logic              early_last;
    logic [ADDR_W-1:0] wr_addr;

    logic signed [DATA_W-1:0] real_sh, imag_sh;

    assign accept     = s_valid && ready_q;
    assign at_last    = (cnt_q == LastIdx);
    assign early_last = accept && s_last && !at_last;

    assign real_sh = $signed(s_real) >>> IN_SHIFT;
    assign imag_sh = $signed(s_imag) >>> IN_SHIFT;

    fft_bitrev #(
        .ADDR_W(ADDR_W)
    ) u_bitrev (
        .value   (cnt_q),
        .reversed(wr_addr)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:     if (accept && at_last) state_d = StStart;
            StStart:    state_d = StWaitDone;
            StWaitDone: if (fft_done) state_d = StLoad;
            default:    state_d = StLoad;
        endcase
    end

    // FSM outputs
    always_comb begin
        fft_start = (state_q == StStart);
    end

    // Counter and busy next-state. An early s_last discards the partial frame.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (accept) begin
            if (at_last || s_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (early_last) begin
                busy_d = 1'b0;
            end else if (cnt_q == '0) begin
                busy_d = 1'b1;
            end
        end else if (state_q == StWaitDone && fft_done) begin
            busy_d = 1'b0;
        end
    end

    // ready is registered from the next state so it is low during reset and drops the cycle
    // after the final beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            ready_q     <= (state_d == StLoad);
            frame_err_q <= accept && (s_last != at_last);
        end
    end

    // Write path: one cycle latency; address and data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_real_q <= '0;
            mem_imag_q <= '0;
        end else begin
            mem_wr_q <= accept;
            if (accept) begin
                mem_addr_q <= wr_addr;
                mem_real_q <= real_sh;
                mem_imag_q <= imag_sh;
            end
        end
    end

    assign s_ready   = ready_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_real  = mem_real_q;
    assign mem_imag  = mem_imag_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: scoreboard of expected memory writes plus per-scenario tasks.
module tb_fft_input_loader;

    localparam int NP = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0, s_last = 1'b0, fft_done = 1'b0;
    logic [15:0] s_real = '0, s_imag = '0;
    logic        s_ready, mem_wr, fft_start, frame_err, busy;
    logic [4:0]  mem_addr;
    logic [15:0] mem_real, mem_imag;

    logic        sh_valid = 1'b0;
    logic [15:0] sh_real = '0, sh_imag = '0;
    logic        sh_ready, sh_mem_wr, sh_fft_start, sh_frame_err, sh_busy;
    logic [4:0]  sh_mem_addr;
    logic [15:0] sh_mem_real, sh_mem_imag;

    always #5 clk = ~clk;

    fft_input_loader #(.N_POINTS(32), .ADDR_W(5), .DATA_W(16), .IN_SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real),
        .s_imag(s_imag), .s_last(s_last), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_real(mem_real), .mem_imag(mem_imag), .fft_start(fft_start), .fft_done(fft_done),
        .frame_err(frame_err), .busy(busy)
    );

    fft_input_loader #(.N_POINTS(32), .ADDR_W(5), .DATA_W(16), .IN_SHIFT(2)) dut_sh (
        .clk(clk), .rst_n(rst_n), .s_valid(sh_valid), .s_ready(sh_ready), .s_real(sh_real),
        .s_imag(sh_imag), .s_last(1'b0), .mem_wr(sh_mem_wr), .mem_addr(sh_mem_addr),
        .mem_real(sh_mem_real), .mem_imag(sh_mem_imag), .fft_start(sh_fft_start),
        .fft_done(1'b0), .frame_err(sh_frame_err), .busy(sh_busy)
    );

    typedef struct {
        int         k;
        logic [4:0] addr;
        logic [15:0] re;
        logic [15:0] im;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   fails = 0;
    int   n_wr, n_start, n_err, start_k, run_len, max_run;
    int   addr_of_k[NP];

    function automatic logic [4:0] brev(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    // Scoreboard monitor: every write must match the oldest expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (fft_start) n_start++;
            if (frame_err) n_err++;
            if (mem_wr) begin
                n_wr++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                tests_run++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected_write: got addr=%0d re=%h im=%h, required no write",
                             mem_addr, mem_real, mem_imag);
                end else begin
                    e = sb_q.pop_front();
                    addr_of_k[e.k] = int'(mem_addr);
                    if (fft_start) start_k = e.k;
                    if ({mem_addr, mem_real, mem_imag} !== {e.addr, e.re, e.im}) begin
                        fails++;
                        $display("FAIL sb_write_k%0d: got addr=%0d re=%h im=%h, required addr=%0d re=%h im=%h",
                                 e.k, mem_addr, mem_real, mem_imag, e.addr, e.re, e.im);
                    end
                end
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic clear_stats();
        n_wr = 0; n_start = 0; n_err = 0; start_k = -1; run_len = 0; max_run = 0;
        for (int i = 0; i < NP; i++) addr_of_k[i] = -1;
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted, valid still high.
    task automatic send_beat(input int k, input logic [15:0] re, input logic [15:0] im,
                             input logic last);
        exp_t e;
        s_valid = 1'b1; s_real = re; s_imag = im; s_last = last;
        for (int c = 0; c < 200; c++) begin
            if (s_ready) begin
                e.k = k; e.addr = brev(k[4:0]); e.re = re; e.im = im;
                sb_q.push_back(e);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        tests_run++;
        fails++;
        $display("FAIL send_timeout_k%0d: got s_ready=0 for 200 cycles, required acceptance", k);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0; s_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({s_ready, mem_wr, mem_addr, mem_real, mem_imag, fft_start, frame_err, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b wr=%b addr=%0d start=%b err=%b busy=%b, required all 0",
                     s_ready, mem_wr, mem_addr, fft_start, frame_err, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready_after: got %b, required 1", s_ready);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        for (int k = 0; k < NP; k++) send_beat(k, 16'(k), 16'(-k), k == NP - 1);
        idle(3);
        tests_run++;
        if (max_run !== NP) begin fails++; $display("FAIL b2b_run: got %0d, required %0d", max_run, NP); end
        tests_run++;
        if (n_start !== 1) begin fails++; $display("FAIL b2b_start_count: got %0d, required 1", n_start); end
        tests_run++;
        if (start_k !== NP - 1) begin fails++; $display("FAIL b2b_start_with_k31: got %0d, required 31", start_k); end
        tests_run++;
        if (addr_of_k[1] !== 16) begin fails++; $display("FAIL b2b_addr_k1: got %0d, required 16", addr_of_k[1]); end
        tests_run++;
        if (addr_of_k[3] !== 24) begin fails++; $display("FAIL b2b_addr_k3: got %0d, required 24", addr_of_k[3]); end
        tests_run++;
        if (n_err !== 0) begin fails++; $display("FAIL b2b_frame_err: got %0d, required 0", n_err); end
    endtask

    task automatic test_wait_done();
        int bad = 0;
        s_valid = 1'b1; s_real = 16'h0abc; s_imag = 16'h0def; s_last = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (s_ready !== 1'b0 || busy !== 1'b1 || mem_wr !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin fails++; $display("FAIL wait_hold: got %0d bad cycles, required 0", bad); end
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        s_valid = 1'b0;
        tests_run++;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL wait_ready_after_done: got %b, required 1", s_ready); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL wait_busy_after_done: got %b, required 0", busy); end
        idle(2);
        tests_run++;
        if (n_wr !== NP) begin fails++; $display("FAIL wait_no_accept: got %0d writes, required %0d", n_wr, NP); end
    endtask

    task automatic test_early_last();
        clear_stats();
        for (int k = 0; k < 10; k++) send_beat(k, 16'(100 + k), 16'(200 + k), k == 9);
        idle(3);
        tests_run++;
        if (n_err !== 1) begin fails++; $display("FAIL early_err_count: got %0d, required 1", n_err); end
        tests_run++;
        if (n_start !== 0) begin fails++; $display("FAIL early_no_start: got %0d, required 0", n_start); end
        tests_run++;
        if ({busy, s_ready} !== 2'b01) begin
            fails++; $display("FAIL early_busy_ready: got busy=%b ready=%b, required 0 1", busy, s_ready);
        end
        clear_stats();
        for (int k = 0; k < NP; k++) send_beat(k, 16'(3 * k), 16'(~k), k == NP - 1);
        idle(3);
        tests_run++;
        if (addr_of_k[0] !== 0) begin fails++; $display("FAIL early_next_addr0: got %0d, required 0", addr_of_k[0]); end
        tests_run++;
        if ({n_start, n_err, n_wr} !== {32'd1, 32'd0, 32'd32}) begin
            fails++; $display("FAIL early_next_frame: got start=%0d err=%0d wr=%0d, required 1 0 32",
                              n_start, n_err, n_wr);
        end
        pulse_done();
        idle(1);
    endtask

    task automatic test_missing_last();
        clear_stats();
        for (int k = 0; k < NP; k++) send_beat(k, 16'(16'h4000 + k), 16'(16'hc000 - k), 1'b0);
        idle(3);
        tests_run++;
        if (n_err !== 1) begin fails++; $display("FAIL missing_err_count: got %0d, required 1", n_err); end
        tests_run++;
        if (n_start !== 1 || start_k !== NP - 1) begin
            fails++; $display("FAIL missing_start: got count=%0d k=%0d, required 1 31", n_start, start_k);
        end
        pulse_done();
        idle(1);
        tests_run++;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL missing_ready_back: got %b, required 1", s_ready); end
    endtask

    task automatic test_in_shift();
        logic [15:0] in_re[2], in_im[2], ex_re[2], ex_im[2];
        logic [4:0]  ex_addr[2];
        bit seen;
        in_re[0] = 16'h8000; in_im[0] = 16'h7fff; ex_re[0] = 16'he000; ex_im[0] = 16'h1fff;
        in_re[1] = 16'h0007; in_im[1] = 16'hfff9; ex_re[1] = 16'h0001; ex_im[1] = 16'hfffe;
        ex_addr[0] = 5'd0; ex_addr[1] = 5'd16;
        for (int i = 0; i < 2; i++) begin
            sh_valid = 1'b1; sh_real = in_re[i]; sh_imag = in_im[i];
            @(negedge clk);
            sh_valid = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                if (sh_mem_wr) seen = 1'b1;
                else @(negedge clk);
            end
            tests_run++;
            if (!seen || {sh_mem_addr, sh_mem_real, sh_mem_imag} !== {ex_addr[i], ex_re[i], ex_im[i]}) begin
                fails++;
                $display("FAIL shift_beat%0d: got wr=%b addr=%0d re=%h im=%h, required addr=%0d re=%h im=%h",
                         i, seen, sh_mem_addr, sh_mem_real, sh_mem_imag, ex_addr[i], ex_re[i], ex_im[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_stats();
        for (int k = 0; k < 20; k++) begin
            idle($urandom_range(0, 3));
            send_beat(k, 16'($urandom), 16'($urandom), 1'b0);
        end
        s_valid = 1'b1; s_real = 16'h2020; s_imag = 16'h2121;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({s_ready, mem_wr, mem_addr, mem_real, mem_imag, fft_start, frame_err, busy} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got ready=%b wr=%b addr=%0d re=%h start=%b err=%b busy=%b, required all 0",
                     s_ready, mem_wr, mem_addr, mem_real, fft_start, frame_err, busy);
        end
        s_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        @(negedge clk);
        send_beat(0, 16'h1234, 16'h4321, 1'b0);
        idle(2);
        tests_run++;
        if (addr_of_k[0] !== 0 || n_wr !== 1) begin
            fails++; $display("FAIL midreset_next_addr: got addr=%0d writes=%0d, required 0 1", addr_of_k[0], n_wr);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_back_to_back();
        test_wait_done();
        test_early_last();
        test_missing_last();
        test_in_shift();
        test_reset_mid_frame();
        tests_run++;
        if (sb_q.size() !== 0) begin
            fails++; $display("FAIL sb_leftover: got %0d pending writes, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200us, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Upstream stage of the 32-point FFT core.
- Accepts a stream of complex samples over a valid/ready handshake.
- Writes each frame into FFT working memory in bit-reversed address order, then pulses fft_start.
- Holds off the next frame until the core returns fft_done, so memory is never overwritten mid-transform.

Parameters:
- N_POINTS, 32, samples per frame; power of two.
- ADDR_W, 5, log2(N_POINTS); width of the memory address.
- DATA_W, 16, width of each real and imaginary component, two's complement.
- IN_SHIFT, 0, arithmetic right shift applied to each component before write, as growth headroom; range 0..ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample.
- s_real  in  DATA_W  sample real part.
- s_imag  in  DATA_W  sample imaginary part.
- s_last  in  1  marks the final sample of a frame.
- mem_wr  out  1  write strobe to FFT memory.
- mem_addr  out  ADDR_W  bit-reversed write address; matches load_data_addr of the core.
- mem_real  out  DATA_W  write data, real part; drives data_real_in.
- mem_imag  out  DATA_W  write data, imaginary part; drives data_imag_in.
- fft_start  out  1  one-cycle start pulse to the core.
- fft_done  in  1  core completion; level or pulse.
- frame_err  out  1  one-cycle pulse on a framing error.
- busy  out  1  high from the first accepted sample until fft_done is seen.

Behaviour:
- Reset values: s_ready=0 while rst_n low; all other outputs 0; counter 0; state LOAD.
- s_ready is 1 the first cycle after reset release.
- States: LOAD, START, WAIT_DONE.
- LOAD:
  - s_ready=1.
  - A beat is accepted when s_valid&&s_ready at a rising edge.
- Write path, registered with one cycle latency:
  - Cycle after acceptance: mem_wr=1, mem_addr=bitrev(cnt), mem_real=s_real>>>IN_SHIFT, mem_imag=s_imag>>>IN_SHIFT.
  - The shift is sign-extending.
  - Otherwise mem_wr=0; address and data hold their last values.
- Counter cnt (ADDR_W bits) increments per accepted beat.
- Accepting a beat with cnt==N_POINTS-1:
  - cnt wraps to 0 and state goes to START.
  - s_ready drops the following cycle, so no beat is accepted there.
- START:
  - Lasts exactly 1 cycle.
  - fft_start=1 in this cycle, which coincides with the final mem_wr. The memory write and the core's start sampling happen on the same edge; the core must read memory no earlier than the next cycle.
  - Then go to WAIT_DONE.
- WAIT_DONE:
  - s_ready=0.
  - Stay until fft_done=1 is sampled; then return to LOAD, with s_ready=1 the next cycle.
  - fft_done sampled in LOAD or START is ignored.
- busy: set on the first accepted beat of a frame (cnt==0); cleared on the edge that leaves WAIT_DONE.
- Framing rules:
  - s_last=1 on an accepted beat with cnt<N_POINTS-1 (early last):
    - That beat is still written.
    - frame_err pulses the next cycle.
    - cnt resets to 0, state stays LOAD, busy clears, no fft_start. The partial frame is discarded and overwritten by the next frame.
  - s_last=0 on the beat with cnt==N_POINTS-1 (missing last): frame_err pulses; the frame is still started normally.
- Simultaneous events: s_valid while s_ready=0 is simply not accepted. The source must hold data (standard valid/ready).
- Reset mid-frame or mid-WAIT_DONE:
  - All state returns to reset values immediately; the partial frame is abandoned.
  - Any fft_start already issued is not retracted.
- bitrev reverses the ADDR_W address bits. Example: cnt=1 -> addr 16; cnt=6 -> addr 12.

Decomposition:
- Shared package fft_pkg:
  - Constants N_POINTS, ADDR_W, DATA_W.
  - Loader state enum {LOAD, START, WAIT_DONE}.
  - Complex sample struct {real, imag}, which the core and unloader also reuse.
- One sub-module, fft_bitrev: combinational, parameterised by ADDR_W. It is reused later by the output unloader.

Test Plan:
- Reset then 32 back-to-back beats, values real=k, imag=-k, s_last on k=31:
  - mem_wr for 32 consecutive cycles.
  - Beat k=1 lands at addr 16 and k=3 at addr 24.
  - fft_start pulses once, in the same cycle as the write of k=31.
  - s_ready stays 0 until fft_done.
- Hold fft_done=0 for 100 cycles after start, with s_valid held 1:
  - No beat is accepted.
  - busy=1 throughout.
  - Raising fft_done for 1 cycle sets s_ready=1 on the next cycle.
- s_last on beat k=9:
  - frame_err pulses once and no fft_start occurs.
  - The next 32-beat frame starts at addr 0 and completes normally.
- s_last=0 on beat 31: frame_err pulses and fft_start still pulses.
- IN_SHIFT=2:
  - Input real=16'h8000 -> mem_real=16'hE000.
  - Input imag=16'h7FFF -> mem_imag=16'h1FFF.
- Random s_valid gaps, then rst_n low for 1 cycle at beat 20:
  - All outputs go to 0 asynchronously.
  - The next frame writes its first beat to addr 0.
